// File: rtl/led_color_ctrl_if.sv
// Bus between the board-side user controls and the LED colour controller.
// master: drives buttons/run and observes outputs; slave: the controller.
interface led_color_ctrl_if #(
  parameter int unsigned N_LEDS = 4
);
  logic [2:0]        i_btn;
  logic              i_run;
  logic [2:0]        o_sel;
  logic [N_LEDS-1:0] o_led;
  logic              o_tick;

  modport master (output i_btn, output i_run, input  o_sel, input  o_led, input  o_tick);
  modport slave  (input  i_btn, input  i_run, output o_sel, output o_led, output o_tick);
endinterface

// File: rtl/led_color_ctrl.sv
// RGB LED colour-select controller: button sync/debounce/edge, colour FSM, walking pattern.
// Optional LEDCTRL_BLINK_EN: blink the frozen pattern on each tick while paused.
module led_color_ctrl #(
  parameter int unsigned N_LEDS     = 4,
  parameter int unsigned PRESC      = 25_000_000,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             i_rst_n,
  led_color_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PW = $clog2(PRESC);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RED,
    ST_GREEN,
    ST_BLUE
  } state_t;

  logic [2:0]        sync1, sync2;
  logic [2:0]        level, level_d;
  logic [2:0]        press;
  logic [CW-1:0]     deb_cnt [3];
  state_t            state, state_next;
  logic [2:0]        sel_q;
  logic [N_LEDS-1:0] pattern, pattern_next;
  logic [N_LEDS-1:0] led_q, led_next;
  logic [PW-1:0]     presc;
  logic              tick;
`ifdef LEDCTRL_BLINK_EN
  logic              phase, phase_next;
`endif

  function automatic logic [2:0] sel_of(input state_t s);
    case (s)
      ST_RED:   return 3'b100;
      ST_GREEN: return 3'b010;
      ST_BLUE:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.i_btn;
      sync2 <= sync1;
    end
  end

  // Level flips on the same edge the count would reach DEB_CYCLES.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            level[i]   <= ~level[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  always_comb begin
    state_next = state;
    if (press[2])      state_next = (state == ST_RED)   ? ST_OFF : ST_RED;
    else if (press[1]) state_next = (state == ST_GREEN) ? ST_OFF : ST_GREEN;
    else if (press[0]) state_next = (state == ST_BLUE)  ? ST_OFF : ST_BLUE;
  end

  assign tick = (presc == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) presc <= '0;
    else          presc <= tick ? '0 : presc + 1'b1;
  end

  // Rotate decision uses the current state, not state_next.
  always_comb begin
    pattern_next = pattern;
    if (tick && bus.i_run && state != ST_OFF)
      pattern_next = (pattern << 1) | (pattern >> (N_LEDS - 1));
`ifdef LEDCTRL_BLINK_EN
    phase_next = (bus.i_run || state == ST_OFF) ? 1'b1 : (tick ? ~phase : phase);
    led_next   = (state_next == ST_OFF || !(bus.i_run || phase_next)) ? '0 : pattern_next;
`else
    led_next   = (state_next == ST_OFF) ? '0 : pattern_next;
`endif
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_OFF;
      sel_q   <= '0;
      pattern <= N_LEDS'(1);
      led_q   <= '0;
    end else begin
      state   <= state_next;
      sel_q   <= sel_of(state_next);
      pattern <= pattern_next;
      led_q   <= led_next;
    end
  end

`ifdef LEDCTRL_BLINK_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) phase <= 1'b1;
    else          phase <= phase_next;
  end
`endif

  assign bus.o_sel  = sel_q;
  assign bus.o_led  = led_q;
  assign bus.o_tick = tick;

endmodule

// File: tb/tb_led_color_ctrl.sv
// Self-checking bench for led_color_ctrl: directed scenarios plus random button/run
// traffic compared every cycle against a latency-pipeline reference model.
module tb_led_color_ctrl;

  localparam int unsigned PRESC = 8;
  localparam int unsigned DEB   = 4;
  localparam int unsigned N     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  led_color_ctrl_if #(.N_LEDS(N)) bus ();

  led_color_ctrl #(.N_LEDS(N), .PRESC(PRESC), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: colour 0=off 1=red 2=green 3=blue.
  int unsigned m_cnt = 0;
  int unsigned m_st  = 0;
  logic [N-1:0] m_pat = 4'b0001;
  logic [N-1:0] m_led = '0;
  logic         m_phase = 1'b1;
  logic [2:0]   m_lvl = '0;
  int unsigned  m_streak [3];
  logic [2:0]   raw_q  [$];
  logic [2:0]   rise_q [$];

  function automatic logic [2:0] exp_sel(input int unsigned c);
    case (c)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_pat = 4'b0001; m_led = '0; m_phase = 1'b1; m_lvl = '0;
    for (int i = 0; i < 3; i++) m_streak[i] = 0;
    raw_q.delete();
    rise_q.delete();
    // a debounced rise takes two edges to reach the colour state
    rise_q.push_back(3'b000);
    rise_q.push_back(3'b000);
  endtask

  task automatic model_step();
    logic        tk, run;
    int unsigned old_st;
    logic [2:0]  sv, rise, ap;
    tk = (m_cnt == PRESC - 1);
    run = bus.i_run;
    old_st = m_st;
    if (tk && run && old_st != 0) m_pat = rotl(m_pat);
    m_phase = (run || old_st == 0) ? 1'b1 : (tk ? ~m_phase : m_phase);
    ap = rise_q.pop_front();
    if (ap[2])      m_st = (m_st == 1) ? 0 : 1;
    else if (ap[1]) m_st = (m_st == 2) ? 0 : 2;
    else if (ap[0]) m_st = (m_st == 3) ? 0 : 3;
    sv = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 3'b000;
    raw_q.push_back(bus.i_btn);
    if (raw_q.size() > 2) raw_q.delete(0);
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      if (sv[i] != m_lvl[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_streak[i] = 0;
          rise[i] = m_lvl[i];
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    rise_q.push_back(rise);
    m_cnt = (m_cnt + 1) % PRESC;
`ifdef LEDCTRL_BLINK_EN
    m_led = (m_st == 0 || !(run || m_phase)) ? '0 : m_pat;
`else
    m_led = (m_st == 0) ? '0 : m_pat;
`endif
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("sel",  32'(bus.o_sel),  32'(exp_sel(m_st)));
    check("led",  32'(bus.o_led),  32'(m_led));
    check("tick", 32'(bus.o_tick), 32'(m_cnt == PRESC - 1));
  end

  task automatic hold_btn(input logic [2:0] b);
    bus.i_btn = b;
    repeat (10) @(negedge clk);
    bus.i_btn = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  // Raise a button at a negedge and count rising edges until o_sel equals want.
  task automatic press_wait(input logic [2:0] b, input logic [2:0] want, output int edges);
    edges = 0;
    bus.i_btn = b;
    for (int i = 1; i <= 30 && edges == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_sel == want) edges = i;
    end
  endtask

  int edges;
  logic [N-1:0] exp_led;
  int found;

  initial begin
    bus.i_btn = 3'($urandom_range(0, 7));
    bus.i_run = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel",  32'(bus.o_sel),  32'h0);
    check("rst_led",  32'(bus.o_led),  32'h0);
    check("rst_tick", 32'(bus.o_tick), 32'h0);
    bus.i_btn = 3'b000;
    rst_n = 1'b1;

    edges = 0;
    for (int i = 1; i <= 20 && edges == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_tick) edges = i;
    end
    check("first_tick_edge", 32'(edges), 32'd7);

    @(negedge clk);
    bus.i_btn = 3'b100;
    repeat (3) @(negedge clk);
    bus.i_btn = 3'b000;
    repeat (12) @(negedge clk);
    check("short_pulse_sel", 32'(bus.o_sel), 32'h0);

    press_wait(3'b100, 3'b100, edges);
    check("press_latency", 32'(edges), 32'(DEB + 4));
    check("red_led_init", 32'(bus.o_led), 32'h1);
    @(negedge clk);
    bus.i_btn = 3'b000;
    repeat (10) @(negedge clk);

    exp_led = m_led;
    for (int r = 0; r < 5; r++) begin
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (bus.o_tick) found = 1;
      end
      check("rotate_tick_seen", 32'(found), 32'd1);
      @(negedge clk);
      exp_led = rotl(exp_led);
      check("rotate_step", 32'(bus.o_led), 32'(exp_led));
    end

    hold_btn(3'b011);
    check("priority_sel", 32'(bus.o_sel), 32'b010);
    hold_btn(3'b010);
    check("toggle_off_sel", 32'(bus.o_sel), 32'b000);
    check("toggle_off_led", 32'(bus.o_led), 32'h0);
    exp_led = m_pat;
    hold_btn(3'b001);
    check("recall_sel", 32'(bus.o_sel), 32'b001);

    hold_btn(3'b010);
    check("green_sel", 32'(bus.o_sel), 32'b010);
    bus.i_run = 1'b0;
    exp_led = m_led;
    repeat (30) begin
      @(negedge clk);
`ifndef LEDCTRL_BLINK_EN
      check("pause_hold", 32'(bus.o_led), 32'(exp_led));
`endif
    end
    bus.i_run = 1'b1;

    hold_btn(3'b001);
    check("blue_sel", 32'(bus.o_sel), 32'b001);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel",  32'(bus.o_sel),  32'h0);
    check("async_rst_led",  32'(bus.o_led),  32'h0);
    check("async_rst_tick", 32'(bus.o_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    press_wait(3'b001, 3'b001, edges);
    check("after_rst_latency", 32'(edges), 32'(DEB + 4));
    check("after_rst_led", 32'(bus.o_led), 32'h1);
    @(negedge clk);
    bus.i_btn = 3'b000;

    for (int k = 0; k < 80; k++) begin
      bus.i_btn = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.i_run = ~bus.i_run;
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        bus.i_btn = 3'b000;
        repeat ($urandom_range(1, 10)) @(negedge clk);
      end
    end
    bus.i_btn = 3'b000;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
